// File: rtl/pipe_stage_chain.sv
// Parametrised chain of pipeline registers with per-stage stall/flush, bubble insertion,
// stall back-propagation and occupancy. Define PIPE_STAGE_CHAIN_PERF_EN for the bubble counter.
module pipe_stage_chain #(
  parameter int unsigned          DATA_W     = 32,
  parameter int unsigned          STAGES     = 4,
  parameter logic [DATA_W-1:0]    RESET_DATA = '0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  input  logic [STAGES-1:0]            stall,
  input  logic [STAGES-1:0]            flush,
  output logic [STAGES-1:0]            stage_valid,
  output logic [STAGES*DATA_W-1:0]     stage_data,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(STAGES+1)-1:0]  occupancy,
  output logic [31:0]                  bubble_count
);

  localparam int unsigned OccW = $clog2(STAGES+1);

  logic [STAGES-1:0] hold_eff;
  logic [STAGES-1:0] valid_q, valid_d;
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];
  logic [OccW-1:0]   occ_q, occ_d;

  // A stall in any older stage freezes every younger one.
  always_comb begin
    hold_eff[STAGES-1] = stall[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      hold_eff[i] = stall[i] | hold_eff[i+1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < STAGES; i++) begin
      data_d[i] = data_q[i];
    end

    if (flush[0]) begin
      valid_d[0] = 1'b0;
    end else if (!hold_eff[0]) begin
      valid_d[0] = in_valid;
      data_d[0]  = in_data;
    end

    for (int i = 1; i < STAGES; i++) begin
      if (flush[i]) begin
        valid_d[i] = 1'b0;
      end else if (hold_eff[i]) begin
        valid_d[i] = valid_q[i];
      end else if (hold_eff[i-1]) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_d = occ_d + OccW'(valid_d[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= RESET_DATA;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  always_comb begin
    stage_data = '0;
    for (int i = 0; i < STAGES; i++) begin
      stage_data[i*DATA_W +: DATA_W] = data_q[i];
    end
  end

  assign in_ready    = ~hold_eff[0];
  assign stage_valid = valid_q;
  assign out_valid   = valid_q[STAGES-1];
  assign out_data    = data_q[STAGES-1];
  assign occupancy   = occ_q;

`ifdef PIPE_STAGE_CHAIN_PERF_EN
  logic        bubble;
  logic [31:0] bubble_count_q, bubble_count_d;

  // Stage i bubbles when it is free to move but its upstream neighbour is frozen.
  assign bubble = |(hold_eff[STAGES-2:0] & ~hold_eff[STAGES-1:1] & ~flush[STAGES-1:1]);

  always_comb begin
    bubble_count_d = bubble_count_q;
    if (bubble && (bubble_count_q != 32'hFFFF_FFFF)) begin
      bubble_count_d = bubble_count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bubble_count_q <= '0;
    end else begin
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bubble_count = bubble_count_q;
`else
  assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed self-checking bench for pipe_stage_chain (STAGES=4, DATA_W=32).
module tb_pipe_stage_chain;

  localparam int unsigned DW = 32;
  localparam int unsigned NS = 4;
`ifdef PIPE_STAGE_CHAIN_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST;
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic [NS-1:0]     stall;
  logic [NS-1:0]     flush;
  logic [NS-1:0]     stage_valid;
  logic [NS*DW-1:0]  stage_data;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [2:0]        occupancy;
  logic [31:0]       bubble_count;

  int n_vec  = 0;
  int n_miss = 0;

  pipe_stage_chain #(.DATA_W(DW), .STAGES(NS), .RESET_DATA('0)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .stall        (stall),
    .flush        (flush),
    .stage_valid  (stage_valid),
    .stage_data   (stage_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .occupancy    (occupancy),
    .bubble_count (bubble_count)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] bub(input int n);
    return PerfEn ? 32'(n) : 32'd0;
  endfunction

  task automatic push(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_data = '0; stall = '0; flush = '0;
    step();
    RST = 1'b0;
    check_eq("rst_valid", stage_valid, 4'b0000);
    check_eq("rst_occ", occupancy, 3'd0);
    check_eq("rst_ready", in_ready, 1'b1);
    check_eq("rst_data", stage_data, 128'd0);
    check_eq("rst_bub", bubble_count, 32'd0);

    // Stream 1..5: first payload exits on the 4th edge.
    push(32'd1); push(32'd2); push(32'd3);
    check_eq("lat_not_yet", out_valid, 1'b0);
    push(32'd4);
    check_eq("lat_out1", out_data, 32'd1);
    check_eq("lat_valid", out_valid, 1'b1);
    check_eq("full_occ", occupancy, 3'd4);
    push(32'd5);
    check_eq("stream_out2", out_data, 32'd2);
    push(32'd10); push(32'd11); push(32'd12); push(32'd13);
    check_eq("fill_data", stage_data, {32'd10, 32'd11, 32'd12, 32'd13});

    // Back-propagated stall from stage 2.
    stall = 4'b0100; in_data = 32'd99;
    #1;
    check_eq("stall_ready", in_ready, 1'b0);
    step();
    check_eq("stall1_valid", stage_valid, 4'b0111);
    check_eq("stall1_occ", occupancy, 3'd3);
    check_eq("stall1_bub", bubble_count, bub(1));
    step();
    check_eq("stall2_data", stage_data, {32'd10, 32'd11, 32'd12, 32'd13});
    check_eq("stall2_bub", bubble_count, bub(2));
    stall = '0; in_valid = 1'b0;
    step();
    check_eq("unstall_valid", stage_valid, 4'b1110);
    check_eq("unstall_out", out_data, 32'd11);

    // Flush beats hold on stage 1.
    RST = 1'b1; step(); RST = 1'b0;
    check_eq("rst2_bub", bubble_count, 32'd0);
    push(32'hAA); push(32'hBB);
    check_eq("fbh_pre_valid", stage_valid, 4'b0011);
    stall = 4'b0010; flush = 4'b0010; in_data = 32'hCC;
    step();
    check_eq("fbh_valid", stage_valid, 4'b0001);
    check_eq("fbh_s0", stage_data[31:0], 32'hBB);
    check_eq("fbh_s1", stage_data[63:32], 32'hAA);
    check_eq("fbh_occ", occupancy, 3'd1);
    check_eq("fbh_bub", bubble_count, bub(1));
    stall = '0; flush = '0;

    // Multi-flush branch squash on a full pipe.
    push(32'd21); push(32'd22); push(32'd23); push(32'd24);
    check_eq("sq_pre_valid", stage_valid, 4'b1111);
    flush = 4'b0011; in_data = 32'd25;
    step();
    flush = '0; in_valid = 1'b0;
    check_eq("sq_valid", stage_valid, 4'b1100);
    check_eq("sq_occ", occupancy, 3'd2);
    check_eq("sq_out", out_data, 32'd22);
    check_eq("sq_s2", stage_data[95:64], 32'd23);

    // Reset mid-stream while stalled.
    push(32'd31); push(32'd32); push(32'd33); push(32'd34);
    stall = 4'b1000; in_valid = 1'b0;
    step();
    check_eq("mid_occ", occupancy, 3'd4);
    check_eq("mid_ready", in_ready, 1'b0);
    RST = 1'b1;
    step();
    RST = 1'b0; stall = '0;
    #1;
    check_eq("mid_rst_valid", stage_valid, 4'b0000);
    check_eq("mid_rst_data", stage_data, 128'd0);
    check_eq("mid_rst_occ", occupancy, 3'd0);
    check_eq("mid_rst_ready", in_ready, 1'b1);

`ifdef PIPE_STAGE_CHAIN_PERF_EN
    // Saturation from a preloaded counter.
    force dut.bubble_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_count_q;
    stall = 4'b0010;
    step(); step(); step();
    check_eq("sat_bub", bubble_count, 32'hFFFF_FFFF);
    stall = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Generic, parametrised chain of pipeline registers that replaces the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block.
- Configurable data width and stage count.
- Per-stage stall and flush inputs; automatic bubble insertion; stall back-propagation; occupancy reporting.
- Sits between datapath stages. The hazard unit drives stall/flush; the datapath consumes per-stage data and valid bits.

Parameters:
- DATA_W, 32: payload width per stage, in bits.
- STAGES, 4: number of register stages, >= 2. Stage 0 is youngest (fetch side); stage STAGES-1 is oldest.
- RESET_DATA, 0: payload value loaded into every stage on reset.

Ports:
- CLK  in  1  clock; rising edge.
- RST  in  1  synchronous reset, active-high.
- in_valid  in  1  producer has a payload for stage 0.
- in_data  in  DATA_W  payload for stage 0.
- in_ready  out  1  stage 0 accepts this cycle (= ~hold_eff[0]).
- stall  in  STAGES  per-stage stall request; bit i = stage i.
- flush  in  STAGES  per-stage kill; bit i = stage i.
- stage_valid  out  STAGES  registered valid bit of each stage.
- stage_data  out  STAGES*DATA_W  registered payloads; stage i occupies bits [i*DATA_W +: DATA_W].
- out_valid  out  1  = stage_valid[STAGES-1].
- out_data  out  DATA_W  = payload of stage STAGES-1.
- occupancy  out  $clog2(STAGES+1)  registered count of valid stages.
- bubble_count  out  32  bubble counter (see Optional Feature).

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high.
- Reset (RST=1 at a rising edge):
  - all stage_valid = 0; all payloads = RESET_DATA; occupancy = 0; bubble_count = 0.
  - RST overrides stall and flush.
  - Reset mid-operation discards all contents; in_ready is 1 in the following cycle.
- Effective hold: hold_eff[i] = OR of stall[j] for j >= i.
  - A stall in an older stage freezes all younger stages, so no payload is overwritten.
- Stage update each edge, evaluated in priority order:
  1. flush[i]=1: valid[i] <= 0; payload unchanged. Flush wins over hold and over incoming data.
  2. hold_eff[i]=1: valid[i] and payload hold.
  3. i>0 and hold_eff[i-1]=1 (upstream frozen): bubble; valid[i] <= 0, payload unchanged.
  4. i=0 otherwise: valid[0] <= in_valid; payload <= in_data.
  5. i>0 otherwise: valid[i] <= valid[i-1]; payload[i] <= payload[i-1].
- Latency: a payload accepted at edge N appears at out_data after edge N+STAGES-1, assuming no holds or flushes.
- The last stage drains unconditionally unless stall[STAGES-1]=1. There is no downstream backpressure port.
- Dropped payloads: a payload in stage i with flush[i]=1 is dropped. A valid payload leaving stage i while stage i+1 is flushed is also dropped; it is not kept.
- occupancy: registered popcount of next-state valid bits. Range 0..STAGES; it cannot wrap.
- Simultaneous stall[i] and flush[i]: stage i empties and stays frozen. Younger stages hold per hold_eff.
- X-safety: stall, flush and in_valid are sampled only at rising edges. Payload is don't-care when the matching valid is 0, but it must never be X after reset.

Optional Feature:
- Macro: PIPE_STAGE_CHAIN_PERF_EN.
- Defined:
  - bubble_count increments by 1 on every edge where at least one stage takes rule 3 (bubble).
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by RST.
- Undefined: bubble_count tied to 0; the counter logic is not synthesised. Port list is identical in both builds.

Test Plan:
- Reset then stream: RST 1 cycle; STAGES=4; in_valid=1 with in_data=1,2,3,4,5 on consecutive cycles -> out_data=1 on the 4th edge after first accept, then 2,3,4,5 on the following edges; occupancy reaches 4.
- Back-propagated stall: full pipe holding 10,11,12,13 (stage 3 = 10); stall=4'b0100 for 2 cycles -> stages 0-2 frozen and in_ready=0; stage 3 drains 10 then shows valid 0 (bubble); bubble_count += 2 with PIPE_STAGE_CHAIN_PERF_EN, stays 0 without.
- Flush beats hold: stage 1 holds 0xAA; stall=4'b0010 and flush=4'b0010 on the same edge -> stage_valid[1]=0, stage 0 frozen, occupancy decreases by 1.
- Multi-flush branch squash: full pipe; flush=4'b0011 for 1 cycle -> stage_valid[1:0]=0 next cycle; stages 2-3 advance normally; occupancy = 2.
- Reset mid-stream: pipe holding 4 valids with stall active; RST=1 -> next cycle stage_valid=0, all payloads=RESET_DATA, occupancy=0, in_ready=1.
- Saturation (PIPE_STAGE_CHAIN_PERF_EN, counter forced to 32'hFFFF_FFFE): 3 bubble cycles -> bubble_count = 32'hFFFF_FFFF and stays there.
